// File: rtl/ram_access_arbiter_pkg.sv
// Shared constants and types for the two-requester RAM access arbiter.
package ram_arb_pkg;

  localparam int DEFAULT_ADDR_SIZE      = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // RAM command opcodes, carried in the top two bits of the command word
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  // One-hot encoding of a requester index
  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side and RAM-side signal bundle of the arbiter.
interface ram_access_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
);
  logic [1:0]             req_i;
  logic [1:0]             we_i;
  logic [2*ADDR_SIZE-1:0] addr_i;
  logic [2*ADDR_SIZE-1:0] wdata_i;
  logic [1:0]             gnt_o;
  logic [1:0]             ack_o;
  logic [1:0]             err_o;
  logic [ADDR_SIZE-1:0]   rdata_o;
  logic                   rdata_valid_o;
  logic [ADDR_SIZE+1:0]   ram_din_o;
  logic                   ram_rx_valid_o;
  logic [ADDR_SIZE-1:0]   ram_dout_i;
  logic                   ram_tx_valid_i;

  // Arbiter side
  modport slave (
    input  req_i, we_i, addr_i, wdata_i, ram_dout_i, ram_tx_valid_i,
    output gnt_o, ack_o, err_o, rdata_o, rdata_valid_o, ram_din_o, ram_rx_valid_o
  );

  // Environment side (requesters plus RAM)
  modport master (
    output req_i, we_i, addr_i, wdata_i, ram_dout_i, ram_tx_valid_i,
    input  gnt_o, ack_o, err_o, rdata_o, rdata_valid_o, ram_din_o, ram_rx_valid_o
  );
endinterface

// File: rtl/ram_access_arbiter_rr2.sv
// Two-way round-robin selector with a registered "last served" pointer.
module ram_arb_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic       any_o,
  output logic       sel_o
);
  logic last_q;
  logic last_d;

  // Lone requester wins outright; on a tie the one not served last wins
  always_comb begin
    any_o  = |req_i;
    sel_o  = (&req_i) ? ~last_q : req_i[1];
    last_d = update_i ? served_i : last_q;
  end

  // Pointer resets as if requester 1 was served last, so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/ram_access_arbiter.sv
// Arbitrates two requesters onto a word-serial RAM command port, caching the
// last issued write and read addresses so repeat accesses skip the address word.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE      = DEFAULT_ADDR_SIZE,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                 clk,
  input logic                 rst,
  ram_access_arbiter_if.slave bus
);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q;
  logic                   sel_q;
  logic [ADDR_SIZE-1:0]   wdata_q;
  logic [ADDR_SIZE-1:0]   wr_shadow_q;
  logic [ADDR_SIZE-1:0]   rd_shadow_q;
  logic                   wr_shadow_vld_q;
  logic                   rd_shadow_vld_q;
  logic [CNT_W-1:0]       tmo_cnt_q;
  logic [1:0]             gnt_q;
  logic [1:0]             ack_q;
  logic [1:0]             err_q;
  logic [ADDR_SIZE-1:0]   rdata_q;
  logic                   rdata_valid_q;
  logic [ADDR_SIZE+1:0]   ram_din_q;
  logic                   ram_rx_valid_q;

  logic                   rr_any;
  logic                   rr_sel;
  logic [ADDR_SIZE-1:0]   req_addr_a  [2];
  logic [ADDR_SIZE-1:0]   req_wdata_a [2];
  logic [ADDR_SIZE-1:0]   req_addr;
  logic [ADDR_SIZE-1:0]   req_wdata;
  logic                   req_we;
  logic                   wr_hit;
  logic                   rd_hit;

  // Split the packed per-requester buses into lanes
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign req_addr_a[gi]  = bus.addr_i[gi*ADDR_SIZE +: ADDR_SIZE];
      assign req_wdata_a[gi] = bus.wdata_i[gi*ADDR_SIZE +: ADDR_SIZE];
    end
  endgenerate

  assign req_addr  = req_addr_a[rr_sel];
  assign req_wdata = req_wdata_a[rr_sel];
  assign req_we    = bus.we_i[rr_sel];
  assign wr_hit    = wr_shadow_vld_q && (wr_shadow_q == req_addr);
  assign rd_hit    = rd_shadow_vld_q && (rd_shadow_q == req_addr);

  ram_arb_rr2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.req_i),
    .update_i (state_q == ST_RESP),
    .served_i (sel_q),
    .any_o    (rr_any),
    .sel_o    (rr_sel)
  );

  // Transaction FSM; every output is a register loaded on the transition into the state that shows it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      sel_q           <= 1'b0;
      wdata_q         <= '0;
      wr_shadow_q     <= '0;
      rd_shadow_q     <= '0;
      wr_shadow_vld_q <= 1'b0;
      rd_shadow_vld_q <= 1'b0;
      tmo_cnt_q       <= '0;
      gnt_q           <= '0;
      ack_q           <= '0;
      err_q           <= '0;
      rdata_q         <= '0;
      rdata_valid_q   <= 1'b0;
      ram_din_q       <= '0;
      ram_rx_valid_q  <= 1'b0;
    end else begin
      ack_q          <= '0;
      err_q          <= '0;
      rdata_valid_q  <= 1'b0;
      ram_rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rr_any) begin
            sel_q          <= rr_sel;
            gnt_q          <= req_onehot(rr_sel);
            wdata_q        <= req_wdata;
            ram_rx_valid_q <= 1'b1;
            if (req_we) begin
              if (wr_hit) begin
                state_q   <= ST_WR_DATA;
                ram_din_q <= {OP_WR_DATA, req_wdata};
              end else begin
                state_q         <= ST_WR_ADDR;
                ram_din_q       <= {OP_WR_ADDR, req_addr};
                wr_shadow_q     <= req_addr;
                wr_shadow_vld_q <= 1'b1;
              end
            end else begin
              if (rd_hit) begin
                state_q   <= ST_RD_CMD;
                ram_din_q <= {OP_RD_DATA, {ADDR_SIZE{1'b0}}};
              end else begin
                state_q         <= ST_RD_ADDR;
                ram_din_q       <= {OP_RD_ADDR, req_addr};
                rd_shadow_q     <= req_addr;
                rd_shadow_vld_q <= 1'b1;
              end
            end
          end
        end
        ST_WR_ADDR: begin
          state_q        <= ST_WR_DATA;
          ram_din_q      <= {OP_WR_DATA, wdata_q};
          ram_rx_valid_q <= 1'b1;
        end
        ST_WR_DATA: begin
          state_q <= ST_RESP;
          ack_q   <= gnt_q;
        end
        ST_RD_ADDR: begin
          state_q        <= ST_RD_CMD;
          ram_din_q      <= {OP_RD_DATA, {ADDR_SIZE{1'b0}}};
          ram_rx_valid_q <= 1'b1;
        end
        ST_RD_CMD: begin
          state_q   <= ST_RD_WAIT;
          tmo_cnt_q <= '0;
        end
        ST_RD_WAIT: begin
          if (bus.ram_tx_valid_i) begin
            state_q       <= ST_RESP;
            rdata_q       <= bus.ram_dout_i;
            rdata_valid_q <= 1'b1;
            ack_q         <= gnt_q;
          end else if (tmo_cnt_q == CNT_LAST) begin
            // The RAM's read-address latch is now suspect, so force a reissue next time
            state_q         <= ST_RESP;
            rdata_q         <= '0;
            rdata_valid_q   <= 1'b1;
            ack_q           <= gnt_q;
            err_q           <= gnt_q;
            rd_shadow_vld_q <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_o          = gnt_q;
  assign bus.ack_o          = ack_q;
  assign bus.err_o          = err_q;
  assign bus.rdata_o        = rdata_q;
  assign bus.rdata_valid_o  = rdata_valid_q;
  assign bus.ram_din_o      = ram_din_q;
  assign bus.ram_rx_valid_o = ram_rx_valid_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomized scoreboard bench for ram_access_arbiter with a RAM responder model.
module tb_ram_access_arbiter;
  localparam int AS  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_access_arbiter_if #(.ADDR_SIZE(AS)) bus ();

  ram_access_arbiter #(.ADDR_SIZE(AS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [9:0] word;
    int         req;
  } word_t;

  typedef struct {
    int         req;
    bit         is_rd;
    bit         err;
    logic [7:0] rdata;
    int         delta;
  } ack_t;

  word_t exp_words[$];
  ack_t  exp_acks[$];
  int    ram_delays[$];

  // Reference model state: memory image, address caches, last served requester
  logic [7:0] ref_mem [256];
  logic [7:0] m_wsh, m_rsh;
  bit         m_wsh_v, m_rsh_v;
  int         m_last;

  // RAM responder state
  logic [7:0] ram_mem [256];
  logic [7:0] ram_wa, ram_ra;
  int         ram_cnt;
  bit         rd_pending;
  int         cyc, last_word_cyc;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [1:0] oh(input int n);
    return (n != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else n_pass++;
  endtask

  // Expected RAM words and completion for one served transaction
  task automatic model_txn(input int n, input bit we, input logic [7:0] a, input logic [7:0] w,
                           input int d);
    word_t wr;
    ack_t  ak;
    wr.req = n;
    if (we) begin
      if (!(m_wsh_v && m_wsh == a)) begin
        wr.word = {2'b00, a};
        exp_words.push_back(wr);
        m_wsh = a;
        m_wsh_v = 1'b1;
      end
      wr.word = {2'b01, w};
      exp_words.push_back(wr);
      ref_mem[a] = w;
      ak = '{req: n, is_rd: 1'b0, err: 1'b0, rdata: 8'h00, delta: 1};
    end else begin
      if (!(m_rsh_v && m_rsh == a)) begin
        wr.word = {2'b10, a};
        exp_words.push_back(wr);
        m_rsh = a;
        m_rsh_v = 1'b1;
      end
      wr.word = {2'b11, 8'h00};
      exp_words.push_back(wr);
      ram_delays.push_back(d);
      if (d == 0) begin
        ak = '{req: n, is_rd: 1'b1, err: 1'b1, rdata: 8'h00, delta: TMO + 1};
        m_rsh_v = 1'b0;
      end else begin
        ak = '{req: n, is_rd: 1'b1, err: 1'b0, rdata: ref_mem[a], delta: d + 1};
      end
    end
    exp_acks.push_back(ak);
    m_last = n;
  endtask

  // d = cycles from read-data word to RAM tx_valid (0 = never answers)
  task automatic do_round(input logic [1:0] mask, input logic [1:0] we,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] w0, input logic [7:0] w1,
                          input int d0, input int d1, input bit withdraw);
    int first;
    logic [1:0] rem;
    int k;
    first = (mask == 2'b11) ? ((m_last == 0) ? 1 : 0) : (mask[1] ? 1 : 0);
    for (int s = 0; s < 2; s++) begin
      int n;
      n = (s == 0) ? first : 1 - first;
      if (mask[n]) begin
        if (n == 0) model_txn(0, we[0], a0, w0, d0);
        else        model_txn(1, we[1], a1, w1, d1);
      end
    end
    bus.we_i    = we;
    bus.addr_i  = {a1, a0};
    bus.wdata_i = {w1, w0};
    bus.req_i   = mask;
    rem = mask;
    k = 0;
    while (rem != 2'b00 && k < 400) begin
      @(negedge clk);
      k++;
      for (int n = 0; n < 2; n++) begin
        if (rem[n] && bus.ack_o[n]) begin
          rem[n] = 1'b0;
          bus.req_i[n] = 1'b0;
        end
      end
      if (withdraw && k == 3) bus.req_i = 2'b00;
    end
    if (rem != 2'b00) begin
      n_checks++;
      $display("FAIL round_ack_wait: outstanding %b, required 00", rem);
      bus.req_i = 2'b00;
    end
  endtask

  task automatic do_reset_test();
    int k;
    model_txn(0, 1'b0, 8'h77, 8'h00, 0);
    bus.we_i   = 2'b00;
    bus.addr_i = {8'h00, 8'h77};
    bus.req_i  = 2'b01;
    k = 0;
    while (!(bus.ram_rx_valid_o && bus.ram_din_o[9:8] == 2'b11) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_test_rd_word_seen", (k < 100) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    bus.req_i = 2'b00;
    @(negedge clk);
    check("rst_mid_outputs", {bus.gnt_o, bus.ack_o, bus.err_o, bus.rdata_o, bus.rdata_valid_o,
                              bus.ram_din_o, bus.ram_rx_valid_o}, 0);
    rst = 1'b0;
    exp_acks.delete();
    exp_words.delete();
    ram_delays.delete();
    m_wsh_v = 1'b0;
    m_rsh_v = 1'b0;
    m_last  = 1;
    repeat (3) @(negedge clk);
    check("rst_no_ack", bus.ack_o, 0);
  endtask

  // Monitor and RAM responder, both acting mid-cycle
  always @(negedge clk) begin
    word_t w;
    ack_t  a;
    int    d;
    cyc++;
    if (rst) begin
      rd_pending = 1'b0;
      ram_cnt = 0;
      bus.ram_tx_valid_i = 1'b0;
      bus.ram_dout_i = 8'h00;
    end else begin
      bus.ram_tx_valid_i = 1'b0;
      bus.ram_dout_i = 8'($urandom);
      if (ram_cnt > 0) begin
        ram_cnt--;
        if (ram_cnt == 0) begin
          bus.ram_tx_valid_i = 1'b1;
          bus.ram_dout_i = ram_mem[ram_ra];
        end
      end else if (!rd_pending && $urandom_range(0, 7) == 0) begin
        bus.ram_tx_valid_i = 1'b1;
      end

      if (bus.ram_rx_valid_o) begin
        if (exp_words.size() == 0) begin
          n_checks++;
          $display("FAIL ram_word: got %03h, required no command", bus.ram_din_o);
        end else begin
          w = exp_words.pop_front();
          check("ram_word", bus.ram_din_o, w.word);
          check("gnt_during_word", bus.gnt_o, oh(w.req));
        end
        last_word_cyc = cyc;
        case (bus.ram_din_o[9:8])
          2'b00: ram_wa = bus.ram_din_o[7:0];
          2'b01: ram_mem[ram_wa] = bus.ram_din_o[7:0];
          2'b10: ram_ra = bus.ram_din_o[7:0];
          default: begin
            rd_pending = 1'b1;
            d = (ram_delays.size() != 0) ? ram_delays.pop_front() : 0;
            ram_cnt = d;
          end
        endcase
      end

      if (bus.ack_o != 2'b00 || bus.err_o != 2'b00 || bus.rdata_valid_o) begin
        if (exp_acks.size() == 0) begin
          n_checks++;
          $display("FAIL ack: got ack %b err %b rv %b, required none", bus.ack_o, bus.err_o,
                   bus.rdata_valid_o);
        end else begin
          a = exp_acks.pop_front();
          check("ack_o", bus.ack_o, oh(a.req));
          check("err_o", bus.err_o, a.err ? oh(a.req) : 2'b00);
          check("rdata_valid_o", bus.rdata_valid_o, a.is_rd);
          if (a.is_rd) check("rdata_o", bus.rdata_o, a.rdata);
          check("ack_latency", cyc - last_word_cyc, a.delta);
        end
        rd_pending = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] mask;
    logic [1:0] we;
    logic [7:0] av [2];
    int dv [2];
    int r;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i) ^ 8'h5A;
      ram_mem[i] = 8'(i) ^ 8'h5A;
    end
    m_wsh_v = 1'b0; m_rsh_v = 1'b0; m_last = 1; m_wsh = '0; m_rsh = '0;
    ram_wa = '0; ram_ra = '0; ram_cnt = 0; rd_pending = 1'b0; cyc = 0; last_word_cyc = 0;
    bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.gnt_o, bus.ack_o, bus.err_o, bus.rdata_o, bus.rdata_valid_o,
                            bus.ram_din_o, bus.ram_rx_valid_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    do_round(2'b01, 2'b01, 8'h3C, 8'h00, 8'hA5, 8'h00, 0, 0, 1'b0);  // write miss
    do_round(2'b10, 2'b00, 8'h00, 8'h3C, 8'h00, 8'h00, 0, 1, 1'b0);  // read miss, fast RAM
    do_round(2'b01, 2'b01, 8'h3C, 8'h00, 8'h5A, 8'h00, 0, 0, 1'b0);  // write shadow hit
    do_round(2'b10, 2'b00, 8'h00, 8'h3C, 8'h00, 8'h00, 0, 0, 1'b0);  // read timeout
    do_round(2'b10, 2'b00, 8'h00, 8'h3C, 8'h00, 8'h00, 0, 16, 1'b0); // reissue, last-cycle answer
    do_round(2'b01, 2'b00, 8'h3C, 8'h00, 8'h00, 8'h00, 3, 0, 1'b1);  // read hit, withdrawn
    do_reset_test();
    do_round(2'b11, 2'b01, 8'h3C, 8'h3C, 8'hC3, 8'h00, 0, 2, 1'b0);  // tie out of reset
    do_round(2'b11, 2'b11, 8'h10, 8'h11, 8'h01, 8'h02, 0, 0, 1'b0);
    do_round(2'b01, 2'b01, 8'h12, 8'h00, 8'h03, 8'h00, 0, 0, 1'b0);
    do_round(2'b11, 2'b00, 8'h10, 8'h11, 8'h00, 8'h00, 4, 5, 1'b0);  // tie after req0 served

    for (int t = 0; t < 80; t++) begin
      mask = 2'($urandom_range(1, 3));
      we   = 2'($urandom);
      for (int n = 0; n < 2; n++) begin
        r = $urandom_range(0, 3);
        av[n] = (r < 2) ? 8'(8'h3C + r) : 8'($urandom);
        r = $urandom_range(0, 9);
        dv[n] = (r == 0) ? 0 : (r == 1) ? 16 : (r == 2) ? 15 : $urandom_range(1, 6);
      end
      do_round(mask, we, av[0], av[1], 8'($urandom), 8'($urandom), dv[0], dv[1],
               (mask != 2'b11) && ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("words_drained", exp_words.size(), 0);
    check("acks_drained", exp_acks.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 8, RAM address and data width.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum RD_WAIT cycles before read abort.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_i  in  2  per-requester access request; held until ack.
REQ-006 we_i  in  2  per-requester 1=write, 0=read.
REQ-007 addr_i  in  16  requester n address at [8n+7:8n].
REQ-008 wdata_i  in  16  requester n write data at [8n+7:8n].
REQ-009 gnt_o  out  2  one-hot, high while requester n is served.
REQ-010 ack_o  out  2  one-cycle completion pulse to requester n.
REQ-011 err_o  out  2  one-cycle pulse with ack_o on read timeout.
REQ-012 rdata_o  out  8  read data, valid with rdata_valid_o.
REQ-013 rdata_valid_o  out  1  one-cycle pulse, coincident with read ack_o.
REQ-014 ram_din_o  out  10  RAM command word {opcode[1:0], payload[7:0]}.
REQ-015 ram_rx_valid_o  out  1  RAM command strobe, one cycle per word.
REQ-016 ram_dout_i  in  8  RAM read data.
REQ-017 ram_tx_valid_i  in  1  RAM read-data valid.

Function
REQ-018 Opcodes SHALL be 00 write-address, 01 write-data, 10 read-address, 11 read-data (payload 8'h00).
REQ-019 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, RESP.
REQ-020 IDLE SHALL select a requester from req_i; with both requesting, grant the one not served last (round-robin); with none, remain IDLE.
REQ-021 From IDLE a write SHALL go to WR_ADDR, or directly to WR_DATA if the write-address shadow is valid and equals the address.
REQ-022 From IDLE a read SHALL go to RD_ADDR, or directly to RD_CMD if the read-address shadow is valid and equals the address.
REQ-023 WR_ADDR, WR_DATA, RD_ADDR, RD_CMD SHALL each drive exactly one ram_rx_valid_o cycle with the matching opcode, then advance (WR_ADDR->WR_DATA->RESP; RD_ADDR->RD_CMD->RD_WAIT).
REQ-024 Issuing an address word SHALL load the corresponding shadow and mark it valid.
REQ-025 RD_WAIT SHALL capture ram_dout_i into rdata_o on ram_tx_valid_i and go to RESP; ram_tx_valid_i outside RD_WAIT SHALL be ignored.
REQ-026 RD_WAIT reaching TIMEOUT_CYCLES cycles without ram_tx_valid_i SHALL go to RESP with err, rdata_o=8'h00, and invalidate the read shadow.
REQ-027 RESP SHALL pulse ack_o (plus rdata_valid_o for reads, err_o on timeout) for the served requester, drop gnt_o, update the round-robin pointer, return to IDLE.
REQ-028 Requester inputs SHALL be sampled only in IDLE; a request withdrawn mid-transaction SHALL still complete and be acked.
REQ-029 Latency SHALL be: write 3 cycles (shadow hit) / 4 (miss) from IDLE grant to ack; read RD_WAIT length plus 3 (hit) / 4 (miss).
REQ-030 All outputs SHALL be registered; ram_rx_valid_o SHALL be low in IDLE, RD_WAIT, RESP.

Reset
REQ-031 rst SHALL force IDLE, all outputs 0, both shadows invalid, timeout counter 0, round-robin pointer so requester 0 wins the first tie.
REQ-032 rst mid-transaction SHALL abort without ack; no RAM command SHALL issue in the reset cycle.

Structure
REQ-033 Package ram_arb_pkg SHALL hold opcode constants, the state enum, and default ADDR_SIZE/TIMEOUT_CYCLES.
REQ-034 Round-robin selection SHALL be sub-module ram_arb_rr2 (2-way, pointer-based, registered pointer).

Verification
REQ-035 After reset, req0 write addr 8'h3C data 8'hA5 -> words 0x03C, 0x1A5 on consecutive cycles, ack_o[0] next cycle.
REQ-036 Then req1 read addr 8'h3C, RAM tx_valid 1 cycle after read-data word -> words 0x23C, 0x300, rdata_o=8'hA5, ack_o[1]+rdata_valid_o together.
REQ-037 Both request simultaneously out of reset, then again -> requester 0 first, then 1, alternating thereafter.
REQ-038 Repeat write to addr 8'h3C with data 8'h5A -> only word 0x15A issued (shadow hit).
REQ-039 Read with ram_tx_valid_i never asserted -> ack_o and err_o after 16 RD_WAIT cycles, rdata_o=8'h00; next read of same address reissues 0x2xx.
REQ-040 rst asserted during RD_WAIT -> next cycle IDLE, no ack, all outputs 0, following write reissues address word.
